// File: rtl/shift_reg_feed_ctrl_if.sv
// Handshake and strobe bundle between the feed controller and its upstream source / shift-register bank.
interface shift_reg_feed_ctrl_if #(
  parameter int BUFFER_COUNT = 16
);
  logic                    start;
  logic                    abort;
  logic                    src_valid;
  logic                    src_ready;
  logic [BUFFER_COUNT-1:0] in_valid;
  logic                    read_en;
  logic [BUFFER_COUNT-1:0] lane_active;
  logic                    busy;
  logic                    done;

  modport master (
    output start, abort, src_valid,
    input  src_ready, in_valid, read_en, lane_active, busy, done
  );

  modport slave (
    input  start, abort, src_valid,
    output src_ready, in_valid, read_en, lane_active, busy, done
  );
endinterface

// File: rtl/shift_reg_feed_ctrl.sv
// Load/drain sequencer for a bank of BUFFER_COUNT shift-register lanes feeding a systolic array.
// Define FEED_CTRL_SKEW_EN to stagger lane activity diagonally (lane i starts i cycles late).
module shift_reg_feed_ctrl #(
  parameter int BUFFER_COUNT = 16,
  parameter int BUFFER_SIZE  = 9
) (
  input  logic                  clk,
  input  logic                  rst,
  shift_reg_feed_ctrl_if.slave  bus
);

`ifdef FEED_CTRL_SKEW_EN
  localparam int SKEW_STEP = 1;
  localparam int DRAIN_LEN = BUFFER_SIZE + BUFFER_COUNT - 1;
`else
  localparam int SKEW_STEP = 0;
  localparam int DRAIN_LEN = BUFFER_SIZE;
`endif

  localparam int LW = $clog2(BUFFER_SIZE + 1);
  localparam int DW = $clog2(DRAIN_LEN + 1);
  localparam logic [LW-1:0] LOAD_LAST  = LW'(BUFFER_SIZE - 1);
  localparam logic [DW-1:0] DRAIN_LAST = DW'(DRAIN_LEN - 1);

  typedef enum logic [1:0] {IDLE, LOAD, DRAIN, DONE} state_e;

  state_e                  state_q, state_d;
  logic [LW-1:0]           load_cnt_q, load_cnt_d;
  logic [DW-1:0]           drain_cnt_q, drain_cnt_d;

  logic                    src_ready_q, src_ready_d;
  logic [BUFFER_COUNT-1:0] in_valid_q, in_valid_d;
  logic                    read_en_q, read_en_d;
  logic [BUFFER_COUNT-1:0] lane_active_q, lane_active_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;

  logic                    beat;
  logic [BUFFER_COUNT-1:0] lane_hit;

  // src_ready_q is only ever high while in LOAD
  assign beat = bus.src_valid & src_ready_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      load_cnt_q    <= '0;
      drain_cnt_q   <= '0;
      src_ready_q   <= 1'b0;
      in_valid_q    <= '0;
      read_en_q     <= 1'b0;
      lane_active_q <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      load_cnt_q    <= load_cnt_d;
      drain_cnt_q   <= drain_cnt_d;
      src_ready_q   <= src_ready_d;
      in_valid_q    <= in_valid_d;
      read_en_q     <= read_en_d;
      lane_active_q <= lane_active_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    load_cnt_d  = load_cnt_q;
    drain_cnt_d = drain_cnt_q;
    unique case (state_q)
      IDLE: begin
        if (bus.start && !bus.abort) begin
          state_d    = LOAD;
          load_cnt_d = '0;
        end
      end
      LOAD: begin
        if (bus.abort) begin
          state_d    = IDLE;
          load_cnt_d = '0;
        end else if (beat) begin
          if (load_cnt_q == LOAD_LAST) begin
            state_d     = DRAIN;
            load_cnt_d  = '0;
            drain_cnt_d = '0;
          end else begin
            load_cnt_d = load_cnt_q + 1'b1;
          end
        end
      end
      DRAIN: begin
        if (bus.abort) begin
          state_d     = IDLE;
          drain_cnt_d = '0;
        end else if (drain_cnt_q == DRAIN_LAST) begin
          state_d     = DONE;
          drain_cnt_d = '0;
        end else begin
          drain_cnt_d = drain_cnt_q + 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d     = IDLE;
        load_cnt_d  = '0;
        drain_cnt_d = '0;
      end
    endcase
  end

  // Window test done in signed arithmetic so a zero skew does not yield a trivially-true compare
  for (genvar g = 0; g < BUFFER_COUNT; g++) begin : g_lane
    localparam logic signed [DW:0] LO   = (DW+1)'(g * SKEW_STEP);
    localparam logic signed [DW:0] SIZE = (DW+1)'(BUFFER_SIZE);
    logic signed [DW:0] rel;
    assign rel         = $signed({1'b0, drain_cnt_d}) - LO;
    assign lane_hit[g] = !rel[DW] && (rel < SIZE);
  end

  // Outputs are registered from next-state values so they line up with the state they describe
  always_comb begin
    src_ready_d   = (state_d == LOAD);
    in_valid_d    = (beat && !bus.abort) ? '1 : '0;
    read_en_d     = (state_d == DRAIN);
    lane_active_d = (state_d == DRAIN) ? lane_hit : '0;
    busy_d        = (state_d != IDLE);
    done_d        = (state_d == DONE);
  end

  assign bus.src_ready   = src_ready_q;
  assign bus.in_valid    = in_valid_q;
  assign bus.read_en     = read_en_q;
  assign bus.lane_active = lane_active_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;

endmodule

// File: tb/tb_shift_reg_feed_ctrl.sv
// Scoreboard bench for shift_reg_feed_ctrl: directed passes push expected output beats, a monitor pops and compares.
module tb_shift_reg_feed_ctrl;
  localparam int BC = 16;
  localparam int BS = 9;
`ifdef FEED_CTRL_SKEW_EN
  localparam int SK = 1;
  localparam int DL = BS + BC - 1;
`else
  localparam int SK = 0;
  localparam int DL = BS;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  shift_reg_feed_ctrl_if #(.BUFFER_COUNT(BC)) bus ();

  shift_reg_feed_ctrl #(.BUFFER_COUNT(BC), .BUFFER_SIZE(BS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic [BC-1:0] iv;
    logic          re;
    logic [BC-1:0] la;
    logic          dn;
  } rec_t;

  rec_t exp_q[$];
  rec_t mon_act, mon_exp;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   busy_cyc, ready_cyc, beat_cyc, done_cyc, read_cyc;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [BC-1:0] lanes(input int c);
    logic [BC-1:0] v;
    for (int i = 0; i < BC; i++) v[i] = (c >= i * SK) && (c < i * SK + BS);
    return v;
  endfunction

  task automatic push_pass(input int drain_cycles, input bit with_done);
    rec_t r;
    for (int k = 0; k < BS - 1; k++) begin
      r = '0; r.iv = '1;
      exp_q.push_back(r);
    end
    for (int c = 0; c < drain_cycles; c++) begin
      r = '0;
      r.iv = (c == 0) ? '1 : '0;
      r.re = 1'b1;
      r.la = lanes(c);
      exp_q.push_back(r);
    end
    if (with_done) begin
      r = '0; r.dn = 1'b1;
      exp_q.push_back(r);
    end
  endtask

  always @(negedge clk) begin
    if (bus.busy) busy_cyc++;
    if (bus.src_ready) ready_cyc++;
    if (bus.src_ready && bus.src_valid) beat_cyc++;
    if (bus.done) done_cyc++;
    if (bus.read_en) read_cyc++;
    if (bus.in_valid != '0 || bus.read_en || bus.done) begin
      mon_act = {bus.in_valid, bus.read_en, bus.lane_active, bus.done};
      if (exp_q.size() == 0) begin
        check("unexpected_output", 64'(mon_act), 64'(0));
      end else begin
        mon_exp = exp_q.pop_front();
        check("output_beat", 64'(mon_act), 64'(mon_exp));
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clr_stats();
    busy_cyc = 0; ready_cyc = 0; beat_cyc = 0; done_cyc = 0; read_cyc = 0;
  endtask

  task automatic start_pass();
    bus.start = 1'b1;
    tick(1);
    bus.start = 1'b0;
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_busy"}, 64'(bus.busy), 64'(0));
    check({tag, "_outs"}, 64'({bus.src_ready, bus.in_valid, bus.read_en, bus.lane_active, bus.done}), 64'(0));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.src_valid = 1'b0;
    clr_stats();
    tick(3);
    check_quiet("reset");
    rst = 1'b0;
    tick(2);

    // Nominal pass, src_valid held high
    clr_stats();
    push_pass(DL, 1'b1);
    bus.src_valid = 1'b1;
    start_pass();
    check("load_ready", 64'(bus.src_ready), 64'(1));
    tick(9 + DL + 1 + 1);
    check("nom_busy_cycles", 64'(busy_cyc), 64'(9 + DL + 1));
    check("nom_beats", 64'(beat_cyc), 64'(9));
    check("nom_read_cycles", 64'(read_cyc), 64'(DL));
    check("nom_done_pulses", 64'(done_cyc), 64'(1));
    check("nom_queue_empty", 64'(exp_q.size()), 64'(0));

    // Backpressure: src_valid 1,0,1,0...
    clr_stats();
    push_pass(DL, 1'b1);
    bus.src_valid = 1'b1;
    start_pass();
    for (int k = 1; k <= 16; k++) begin
      tick(1);
      bus.src_valid = (k % 2 == 0);
    end
    tick(1 + DL + 1 + 1);
    check("bp_ready_cycles", 64'(ready_cyc), 64'(17));
    check("bp_beats", 64'(beat_cyc), 64'(9));
    check("bp_read_cycles", 64'(read_cyc), 64'(DL));
    check("bp_done_pulses", 64'(done_cyc), 64'(1));
    check("bp_queue_empty", 64'(exp_q.size()), 64'(0));

    // Abort at drain cycle 5
    clr_stats();
    push_pass(6, 1'b0);
    bus.src_valid = 1'b1;
    start_pass();
    tick(9 + 5);
    bus.abort = 1'b1;
    tick(1);
    bus.abort = 1'b0;
    check_quiet("abort");
    tick(3);
    check("abort_read_cycles", 64'(read_cyc), 64'(6));
    check("abort_no_done", 64'(done_cyc), 64'(0));
    check("abort_queue_empty", 64'(exp_q.size()), 64'(0));

    // Reset held 3 cycles mid-DRAIN, then a clean pass
    clr_stats();
    push_pass(4, 1'b0);
    start_pass();
    tick(9 + 3);
    rst = 1'b1;
    tick(1);
    check_quiet("rst_hold");
    tick(2);
    rst = 1'b0;
    check_quiet("rst_release");
    check("rst_read_cycles", 64'(read_cyc), 64'(4));
    check("rst_queue_empty", 64'(exp_q.size()), 64'(0));
    clr_stats();
    push_pass(DL, 1'b1);
    start_pass();
    check("rst_clean_load", 64'({bus.busy, bus.src_ready, bus.read_en}), 64'(3'b110));
    tick(9 + DL + 1 + 1);
    check("rst_clean_beats", 64'(beat_cyc), 64'(9));
    check("rst_clean_done", 64'(done_cyc), 64'(1));
    check("rst_clean_queue", 64'(exp_q.size()), 64'(0));

    // Start pulsed during LOAD and during DONE is ignored
    clr_stats();
    push_pass(DL, 1'b1);
    start_pass();
    tick(3);
    bus.start = 1'b1;
    tick(1);
    bus.start = 1'b0;
    tick(9 + DL - 4);
    check("done_cycle_pulse", 64'(bus.done), 64'(1));
    bus.start = 1'b1;
    tick(1);
    bus.start = 1'b0;
    check("no_restart_busy", 64'(bus.busy), 64'(0));
    tick(3);
    check("ign_busy_cycles", 64'(busy_cyc), 64'(9 + DL + 1));
    check("ign_done_pulses", 64'(done_cyc), 64'(1));
    check("ign_queue_empty", 64'(exp_q.size()), 64'(0));

    // Abort together with start in IDLE keeps the controller idle
    clr_stats();
    bus.abort = 1'b1;
    bus.start = 1'b1;
    tick(1);
    bus.abort = 1'b0;
    bus.start = 1'b0;
    check_quiet("abort_start");
    tick(2);
    check("abort_start_busy_cycles", 64'(busy_cyc), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/shift_reg_feed_ctrl.md
SHIFT_REG_FEED_CTRL -- requirements
Module: shift_reg_feed_ctrl

Interface
REQ-001 SHALL have parameter BUFFER_COUNT, default 16, number of shift-register lanes driven.
REQ-002 SHALL have parameter BUFFER_SIZE, default 9, words held per lane.
REQ-003 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port start  input  1  one-cycle request to begin a load/drain pass.
REQ-006 SHALL have port abort  input  1  terminate current pass, return to IDLE.
REQ-007 SHALL have port src_valid  input  1  upstream has one word per lane on the shared data bus.
REQ-008 SHALL have port src_ready  output  1  controller accepts a load beat this cycle.
REQ-009 SHALL have port in_valid  output  BUFFER_COUNT  per-lane write strobe to the shift-register bank.
REQ-010 SHALL have port read_en  output  1  shift/read strobe to the bank.
REQ-011 SHALL have port lane_active  output  BUFFER_COUNT  per-lane flag marking a valid word at the bank output toward the array.
REQ-012 SHALL have port busy  output  1  high in any state other than IDLE.
REQ-013 SHALL have port done  output  1  one-cycle pulse at pass completion.

Function
REQ-014 SHALL implement states IDLE, LOAD, DRAIN, DONE.
REQ-015 IDLE -> LOAD on start=1; start in any other state is ignored.
REQ-016 In LOAD, src_ready=1; a beat = src_valid & src_ready; on each beat in_valid = all ones, else all zeros.
REQ-017 SHALL count load beats with a counter of width clog2(BUFFER_SIZE+1); after beat BUFFER_SIZE, next state DRAIN, with src_ready=0 from the following cycle.
REQ-018 src_valid=0 in LOAD stalls the count; no timeout.
REQ-019 In DRAIN, read_en=1 every cycle for exactly DRAIN_LEN cycles (see REQ-027), counted by a drain counter starting at 0.
REQ-020 In DRAIN, lane_active[i]=1 when drain counter c satisfies SKEW(i) <= c < SKEW(i)+BUFFER_SIZE, else 0.
REQ-021 After the last DRAIN cycle -> DONE; DONE lasts one cycle with done=1, then IDLE.
REQ-022 in_valid, read_en, src_ready and lane_active SHALL be zero outside LOAD/DRAIN respectively; all outputs registered, so outputs change one cycle after the state/counter that causes them.
REQ-023 abort=1 in LOAD or DRAIN -> IDLE next cycle, counters cleared, no done pulse; abort in IDLE/DONE has no effect; abort and start together in IDLE: abort wins.
REQ-024 A start arriving in the DONE cycle is ignored; new pass requires start in IDLE.

Reset
REQ-025 rst=1 at a clock edge SHALL force IDLE, clear both counters, drive src_ready, in_valid, read_en, lane_active, busy, done to 0; takes priority over start and abort.
REQ-026 Reset mid-LOAD or mid-DRAIN SHALL discard the pass; the bank contents are not cleared by this block.

Configuration
REQ-027 Macro FEED_CTRL_SKEW_EN: when defined, SKEW(i)=i and DRAIN_LEN=BUFFER_SIZE+BUFFER_COUNT-1, giving the diagonal wavefront the systolic array needs; when undefined, SKEW(i)=0 and DRAIN_LEN=BUFFER_SIZE, all lanes active together.

Verification
REQ-028 Reset: hold rst 3 cycles mid-DRAIN -> all outputs 0, busy=0, next start begins a clean LOAD.
REQ-029 Nominal (defaults, SKEW_EN defined): start, src_valid held 1 -> 9 in_valid beats, then read_en high 24 cycles, lane_active[0] cycles 0-8, lane_active[15] cycles 15-23, done pulse once, total busy = 9+24+1 cycles.
REQ-030 Backpressure: src_valid toggled 1,0,1,0... -> exactly 9 beats counted over 17 cycles, DRAIN starts after 9th beat.
REQ-031 Abort: abort asserted at drain cycle 5 -> read_en low next cycle, no done, busy=0.
REQ-032 Start ignored: start pulsed during LOAD and during DONE -> no restart, single done pulse.
REQ-033 SKEW_EN undefined: nominal pass -> read_en 9 cycles, lane_active all ones for those 9 cycles.
